ll_req_master: RTL

Host-side initiator for the linked-list request/response interface. It buffers host commands in a small FIFO and issues them one at a time as `req_*` transactions to the linked-list controller. It collects each `resp_*` reply with a single-cycle `resp_taken` and presents the reply to the host through a one-entry valid/ready output slot. It sits between the system host (or test sequencer) and the linked-list controller, and also keeps request and error statistics.

---
 rtl/ll_req_master_pkg.sv | 43 ++++
 rtl/ll_cmd_fifo.sv | 64 ++++++
 rtl/ll_req_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ll_req_master_pkg.sv
// Shared linked-list types and widths used by the request master and its command FIFO.
package ll_req_master_pkg;

  localparam int PTR_WD     = 4;
  localparam int WR_DATA_WD = 8;

  typedef enum logic [2:0] {
    REQ_NONE   = 3'd0,
    PUSH_HEAD  = 3'd1,
    PUSH_TAIL  = 3'd2,
    POP_HEAD   = 3'd3,
    POP_TAIL   = 3'd4,
    READ_NODE  = 3'd5,
    WRITE_NODE = 3'd6
  } t_req_types;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    OP_DONE   = 2'd1,
    ERROR     = 2'd2
  } t_resp_types;

  typedef enum logic [WR_DATA_WD-1:0] {
    NO_ERROR         = 8'h00,
    POP_LL_EMPTY     = 8'h01,
    LL_FULL          = 8'h02,
    PTR_OUT_OF_RANGE = 8'h03
  } t_error_types;

  // One buffered host command, packed {type, pos, data}
  typedef struct packed {
    t_req_types              typ;
    logic [PTR_WD-1:0]       pos;
    logic [WR_DATA_WD-1:0]   data;
  } t_cmd_entry;

  localparam int CMD_ENTRY_WD = $bits(t_cmd_entry);

  function automatic logic resp_is_err(input t_resp_types t);
    return (t == ERROR);
  endfunction

endpackage

// File: rtl/ll_cmd_fifo.sv
// Parameterised synchronous FIFO with full/empty flags; pointers carry one wrap bit.
module ll_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: clearing the pointers makes every entry unreachable
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/ll_req_master.sv
// Host-side initiator: buffers commands, issues them one at a time to the linked-list
// controller and returns replies through a one-entry result slot. Watchdog: LL_REQ_TIMEOUT_EN.
module ll_req_master
  import ll_req_master_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_WD      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_vld,
  output logic                  cmd_ready,
  input  t_req_types            cmd_type,
  input  logic [PTR_WD-1:0]     cmd_pos,
  input  logic [WR_DATA_WD-1:0] cmd_data,
  output logic                  req_vld,
  output t_req_types            req_type,
  output logic [PTR_WD-1:0]     req_pos,
  output logic [WR_DATA_WD-1:0] req_data,
  input  logic                  intf_ready,
  input  logic                  resp_vld,
  input  t_resp_types           resp_type,
  input  logic [WR_DATA_WD-1:0] resp_data,
  input  logic                  resp_data_vld,
  output logic                  resp_taken,
  output logic                  out_vld,
  input  logic                  out_ready,
  output t_resp_types           out_type,
  output logic [WR_DATA_WD-1:0] out_data,
  output logic                  out_data_vld,
  output logic                  out_timeout,
  output logic                  busy,
  output logic [CNT_WD-1:0]     req_cnt,
  output logic [CNT_WD-1:0]     err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_TAKE      = 3'd3,
    S_DRAIN     = 3'd4
  } t_state;

  localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

  t_state                state_q, state_d;
  t_req_types            req_type_q, req_type_d;
  logic [PTR_WD-1:0]     req_pos_q, req_pos_d;
  logic [WR_DATA_WD-1:0] req_data_q, req_data_d;
  logic                  out_vld_q, out_vld_d;
  t_resp_types           out_type_q, out_type_d;
  logic [WR_DATA_WD-1:0] out_data_q, out_data_d;
  logic                  out_data_vld_q, out_data_vld_d;
  logic [CNT_WD-1:0]     req_cnt_q, req_cnt_d;
  logic [CNT_WD-1:0]     err_cnt_q, err_cnt_d;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  slot_free_s;
  logic                  capture_s;
  logic                  tmo_fire_s;
  logic                  err_inc_s;
  t_cmd_entry            fifo_din_s;
  t_cmd_entry            fifo_dout_s;

  assign cmd_ready   = ~fifo_full_s;
  assign push_s      = cmd_vld & ~fifo_full_s;
  assign slot_free_s = ~out_vld_q | out_ready;
  assign fifo_din_s  = '{typ: cmd_type, pos: cmd_pos, data: cmd_data};

  ll_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_ENTRY_WD)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .din_i   (fifo_din_s),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

`ifdef LL_REQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TMO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TMO_ONE  = TO_W'(1);

  logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_expired_s;
  logic            out_timeout_q, out_timeout_d;

  assign tmo_expired_s = (tmo_cnt_q == TMO_LAST);

  // Watchdog counts only while waiting; holds at the limit until the slot frees
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == S_WAIT_RESP) begin
      if (tmo_expired_s) begin
        tmo_cnt_d = tmo_cnt_q;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  always_comb begin
    out_timeout_d = out_timeout_q;
    if (capture_s) begin
      out_timeout_d = 1'b0;
    end else if (tmo_fire_s) begin
      out_timeout_d = 1'b1;
    end else if (out_ready) begin
      out_timeout_d = 1'b0;
    end else begin
      out_timeout_d = out_timeout_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q     <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign out_timeout = out_timeout_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYC;
  assign out_timeout      = 1'b0;
`endif

  // Transaction sequencing; the response wins over a simultaneous watchdog expiry
  always_comb begin
    state_d    = state_q;
    pop_s      = 1'b0;
    capture_s  = 1'b0;
    tmo_fire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s && intf_ready) begin
          state_d = S_ISSUE;
          pop_s   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (resp_vld && slot_free_s) begin
          state_d = S_TAKE;
`ifdef LL_REQ_TIMEOUT_EN
        end else if (tmo_expired_s && slot_free_s) begin
          state_d    = S_IDLE;
          tmo_fire_s = 1'b1;
`endif
        end else begin
          state_d = S_WAIT_RESP;
        end
      end
      S_TAKE: begin
        capture_s = 1'b1;
        state_d   = S_DRAIN;
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields load on pop and stay put until the next pop
  always_comb begin
    req_type_d = req_type_q;
    req_pos_d  = req_pos_q;
    req_data_d = req_data_q;
    if (pop_s) begin
      req_type_d = fifo_dout_s.typ;
      req_pos_d  = fifo_dout_s.pos;
      req_data_d = fifo_dout_s.data;
    end else begin
      req_type_d = req_type_q;
      req_pos_d  = req_pos_q;
      req_data_d = req_data_q;
    end
  end

  // Result slot: a new capture reloads even while the host is draining it
  always_comb begin
    out_vld_d      = out_vld_q;
    out_type_d     = out_type_q;
    out_data_d     = out_data_q;
    out_data_vld_d = out_data_vld_q;
    if (capture_s) begin
      out_vld_d      = 1'b1;
      out_type_d     = resp_type;
      out_data_d     = resp_data;
      out_data_vld_d = resp_data_vld;
    end else if (tmo_fire_s) begin
      out_vld_d      = 1'b1;
      out_type_d     = ERROR;
      out_data_d     = '0;
      out_data_vld_d = 1'b0;
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  assign err_inc_s = (capture_s && resp_is_err(resp_type)) || tmo_fire_s;

  // Saturating statistics
  always_comb begin
    req_cnt_d = req_cnt_q;
    err_cnt_d = err_cnt_q;
    if ((state_q == S_ISSUE) && (req_cnt_q != '1)) begin
      req_cnt_d = req_cnt_q + CNT_ONE;
    end else begin
      req_cnt_d = req_cnt_q;
    end
    if (err_inc_s && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      req_type_q     <= REQ_NONE;
      req_pos_q      <= '0;
      req_data_q     <= '0;
      out_vld_q      <= 1'b0;
      out_type_q     <= RESP_NONE;
      out_data_q     <= '0;
      out_data_vld_q <= 1'b0;
      req_cnt_q      <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      req_type_q     <= req_type_d;
      req_pos_q      <= req_pos_d;
      req_data_q     <= req_data_d;
      out_vld_q      <= out_vld_d;
      out_type_q     <= out_type_d;
      out_data_q     <= out_data_d;
      out_data_vld_q <= out_data_vld_d;
      req_cnt_q      <= req_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign req_vld      = (state_q == S_ISSUE);
  assign resp_taken   = (state_q == S_TAKE);
  assign req_type     = req_type_q;
  assign req_pos      = req_pos_q;
  assign req_data     = req_data_q;
  assign out_vld      = out_vld_q;
  assign out_type     = out_type_q;
  assign out_data     = out_data_q;
  assign out_data_vld = out_data_vld_q;
  assign busy         = (state_q != S_IDLE) | ~fifo_empty_s;
  assign req_cnt      = req_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule
